nabp_angle_feeder: RTL and testbench
====================================

// Module: nabp_angle_feeder
// PURPOSE
//   Host-side responder to the filtered RAM swap control's angle handshake.
//   Answers each next-angle request with an angle, a has-next flag and an
//   ack pulse. Serves the sample reads the filling swappable issues for the
//   accepted angle by mapping {angle index, s} onto the sinogram memory
//   address. Sits between the sinogram memory/FIR front end and the swap
//   control.
// PARAMETERS
//   kAngleLength  8    width of angle value
//   kSLength      9    width of projection sample index s
//   kIdxLength    8    width of angle index (memory row)
//   kDataLength   16   sinogram sample width
//   kNoOfAngles   180  angles per scan (1..2^kIdxLength)
//   kAngleStep    1    angle increment per index
//   kMemLatency   2    sinogram memory read latency in cycles (>=1)
// PORTS
//   clk               in   1              system clock
//   reset             in   1              async reset, active-high
//   start             in   1              begin scan (1-cycle pulse)
//   busy              out  1              scan in progress
//   done              out  1              1-cycle pulse, all angles issued
//   hs_next_angle     in   1              swap control requests next angle
//   hs_angle          out  kAngleLength   angle offered to swap control
//   hs_has_next_angle out  1              an unissued angle remains
//   hs_next_angle_ack out  1              1-cycle acceptance pulse
//   hs_s_val          in   kSLength       sample address from filling swappable
//   mem_addr          out  kIdxLength+kSLength  {fill_idx, s} read address
//   mem_rd            out  1              read enable
//   mem_data          in   kDataLength    memory read data, kMemLatency later
//   hs_val            out  kDataLength    raw sample toward FIR/filled RAM
// BEHAVIOUR
//   Reset (async, any time incl. mid-scan): state=IDLE, busy=0, done=0,
//     hs_angle=0, hs_has_next_angle=0, hs_next_angle_ack=0, mem_rd=0,
//     mem_addr=0, hs_val=0, idx=0, fill_idx=0. The data pipe is flushed.
//   FSM: IDLE -> (start) OFFER -> (hs_next_angle) ACK -> OFFER | LAST -> IDLE.
//   IDLE: start loads idx=0, hs_angle=0, hs_has_next_angle=1, busy=1.
//     start while busy is ignored.
//   OFFER: hs_angle/hs_has_next_angle are stable. On the first cycle in which
//     hs_next_angle=1, register hs_next_angle_ack=1 for exactly one cycle.
//   ACK cycle (ack=1): hs_angle holds the accepted angle, because the swap
//     control samples it during this cycle. On the next edge: fill_idx<=idx,
//     ack<=0, idx<=idx+1, hs_angle<=hs_angle+kAngleStep (mod 2^kAngleLength).
//     If idx was kNoOfAngles-1: hs_has_next_angle<=0, go to LAST.
//     Otherwise return to OFFER.
//   After each ack, ack is not re-asserted for at least 1 cycle, even if
//     hs_next_angle stays high.
//   LAST: hs_has_next_angle=0 and no further ack. The swap control rotates
//     without ack. After one cycle: done=1 for one cycle, busy=0, IDLE.
//     fill_idx is retained so the final fill completes.
//   Read path, free-running while busy or in the final fill:
//     mem_addr <= {fill_idx, hs_s_val}, mem_rd <= busy|LAST (1 register).
//     hs_val = mem_data, registered once.
//     Total hs_s_val -> hs_val latency = kMemLatency+2 cycles, fixed.
//     The swappable's delay compensation is programmed to this value.
//   Simultaneous events: a request in the same cycle as start is honoured
//     no earlier than the cycle after busy rises.
//   kNoOfAngles=1: the first ack goes directly to LAST.
// STRUCTURE
//   Shared package/defines: kAngleLength, kSLength, kIdxLength, kDataLength,
//     kNoOfAngles, kAngleStep, and the state encodings IDLE/OFFER/ACK/LAST.
//   Sub-module nabp_fixed_delay_line (width, depth): used for the read-data
//     pipe alignment; it is reused by the swappable.
//   Remainder is a single FSM plus idx, angle and fill_idx counters.
// TESTING
//   Reset, start, request held high: ack pulses exactly 3 times for
//     kNoOfAngles=3, with hs_angle 0,1,2 sampled at ack. has_next falls after
//     the 3rd ack. done pulses once, busy falls.
//   Request held continuously: there is >=1 idle cycle between acks, and no
//     double ack per angle.
//   Read path: after the 2nd ack, drive hs_s_val=5. Then mem_addr={1,5}, and
//     hs_val equals the memory word at row 1, col 5 after kMemLatency+2 cycles.
//   Angle wrap: kAngleStep=100, kAngleLength=8, 4 angles -> 0,100,200,44.
//   Assert reset during the 2nd OFFER: all outputs go to 0 immediately.
//     A new start restarts at angle 0, fill_idx 0.
//   start pulsed while busy: no effect on idx or hs_angle. kNoOfAngles=1:
//     single ack, then done.

Source files
------------

// File: rtl/nabp_angle_feeder_pkg.sv
// Shared constants, state encoding and latency helper for the angle feeder
// and the swap-control side that must agree with its read timing.
package nabp_angle_feeder_pkg;

    localparam int kDefAngleLength = 8;
    localparam int kDefSLength     = 9;
    localparam int kDefIdxLength   = 8;
    localparam int kDefDataLength  = 16;
    localparam int kDefNoOfAngles  = 180;
    localparam int kDefAngleStep   = 1;
    localparam int kDefMemLatency  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        ACK   = 2'd2,
        LAST  = 2'd3
    } feeder_state_e;

    // s -> sample latency: address register, memory, output register.
    function automatic int feeder_read_latency(input int mem_latency);
        return mem_latency + 2;
    endfunction

endpackage

// File: rtl/nabp_angle_feeder_if.sv
// Angle handshake and sample-read bundle between the feeder (master) and the
// filtered RAM swap control / filling swappable (slave).
interface nabp_angle_feeder_if #(
    parameter int kAngleLength = nabp_angle_feeder_pkg::kDefAngleLength,
    parameter int kSLength     = nabp_angle_feeder_pkg::kDefSLength,
    parameter int kDataLength  = nabp_angle_feeder_pkg::kDefDataLength
);

    logic                    hs_next_angle;
    logic [kAngleLength-1:0] hs_angle;
    logic                    hs_has_next_angle;
    logic                    hs_next_angle_ack;
    logic [kSLength-1:0]     hs_s_val;
    logic [kDataLength-1:0]  hs_val;

    modport master (
        input  hs_next_angle,
        input  hs_s_val,
        output hs_angle,
        output hs_has_next_angle,
        output hs_next_angle_ack,
        output hs_val
    );

    modport slave (
        output hs_next_angle,
        output hs_s_val,
        input  hs_angle,
        input  hs_has_next_angle,
        input  hs_next_angle_ack,
        input  hs_val
    );

endinterface

// File: rtl/nabp_fixed_delay_line.sv
// Fixed-depth register pipe with async reset; depth 0 degenerates to a wire.
module nabp_fixed_delay_line #(
    parameter int kWidth = 16,
    parameter int kDepth = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [kWidth-1:0] din,
    output logic [kWidth-1:0] dout
);

    generate
        if (kDepth == 0) begin : g_wire
            assign dout = din;
        end else begin : g_pipe
            logic [kDepth-1:0][kWidth-1:0] stage_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg[0] <= din;
                    for (int i = 1; i < kDepth; i++) begin
                        stage_reg[i] <= stage_reg[i-1];
                    end
                end
            end

            assign dout = stage_reg[kDepth-1];
        end
    endgenerate

endmodule

// File: rtl/nabp_angle_feeder.sv
// Answers next-angle requests from the swap control and serves the filling
// swappable's sample reads from the sinogram memory at a fixed latency.
module nabp_angle_feeder
    import nabp_angle_feeder_pkg::*;
#(
    parameter int kAngleLength = kDefAngleLength,
    parameter int kSLength     = kDefSLength,
    parameter int kIdxLength   = kDefIdxLength,
    parameter int kDataLength  = kDefDataLength,
    parameter int kNoOfAngles  = kDefNoOfAngles,
    parameter int kAngleStep   = kDefAngleStep,
    parameter int kMemLatency  = kDefMemLatency
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    nabp_angle_feeder_if.master            hs,
    output logic [kIdxLength+kSLength-1:0] mem_addr,
    output logic                           mem_rd,
    input  logic [kDataLength-1:0]         mem_data
);

    localparam logic [kIdxLength-1:0]   kLastIdx  = kIdxLength'(kNoOfAngles - 1);
    localparam logic [kAngleLength-1:0] kStep     = kAngleLength'(kAngleStep);
    localparam int kReadLatency   = feeder_read_latency(kMemLatency);
    // The address register supplies one cycle of the total read latency.
    localparam int kDataPipeDepth = kReadLatency - kMemLatency - 1;

    feeder_state_e           state_reg, state_next;
    logic [kIdxLength-1:0]   idx_reg, idx_next;
    logic [kIdxLength-1:0]   fill_idx_reg, fill_idx_next;
    logic [kAngleLength-1:0] angle_reg, angle_next;
    logic                    has_next_reg, has_next_next;
    logic                    ack_reg, ack_next;
    logic                    busy_reg, busy_next;
    logic                    done_reg, done_next;

    logic [kIdxLength+kSLength-1:0] mem_addr_reg;
    logic                           mem_rd_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            fill_idx_reg <= '0;
            angle_reg    <= '0;
            has_next_reg <= 1'b0;
            ack_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            fill_idx_reg <= fill_idx_next;
            angle_reg    <= angle_next;
            has_next_reg <= has_next_next;
            ack_reg      <= ack_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        fill_idx_next = fill_idx_reg;
        angle_next    = angle_reg;
        has_next_next = has_next_reg;
        busy_next     = busy_reg;
        ack_next      = 1'b0;
        done_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next    = OFFER;
                    idx_next      = '0;
                    angle_next    = '0;
                    has_next_next = 1'b1;
                    busy_next     = 1'b1;
                end
            end
            OFFER: begin
                if (hs.hs_next_angle) begin
                    ack_next   = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                // Angle is held through this cycle; the swap control samples it now.
                fill_idx_next = idx_reg;
                idx_next      = idx_reg + 1'b1;
                angle_next    = angle_reg + kStep;
                if (idx_reg == kLastIdx) begin
                    has_next_next = 1'b0;
                    state_next    = LAST;
                end else begin
                    state_next = OFFER;
                end
            end
            LAST: begin
                busy_next  = 1'b0;
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Read path runs every cycle so the swappable sees a constant latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr_reg <= '0;
            mem_rd_reg   <= 1'b0;
        end else begin
            mem_addr_reg <= {fill_idx_reg, hs.hs_s_val};
            mem_rd_reg   <= busy_reg | (state_reg == LAST);
        end
    end

    nabp_fixed_delay_line #(
        .kWidth (kDataLength),
        .kDepth (kDataPipeDepth)
    ) u_data_pipe (
        .clk   (clk),
        .reset (reset),
        .din   (mem_data),
        .dout  (hs.hs_val)
    );

    assign busy                 = busy_reg;
    assign done                 = done_reg;
    assign hs.hs_angle          = angle_reg;
    assign hs.hs_has_next_angle = has_next_reg;
    assign hs.hs_next_angle_ack = ack_reg;
    assign mem_addr             = mem_addr_reg;
    assign mem_rd               = mem_rd_reg;

endmodule

// File: tb/tb_nabp_angle_feeder.sv
// Directed scoreboard bench: three feeder instances (3 angles, wrapping step,
// single angle) share clock and reset.
module tb_nabp_angle_feeder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        start_a, start_b, start_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic [16:0] mem_addr_a, mem_addr_b, mem_addr_c;
    logic        mem_rd_a, mem_rd_b, mem_rd_c;
    logic [15:0] mem_data_a, mem_data_b, mem_data_c;

    nabp_angle_feeder_if #(.kAngleLength(8), .kSLength(9), .kDataLength(16)) if_a ();
    nabp_angle_feeder_if #(.kAngleLength(8), .kSLength(9), .kDataLength(16)) if_b ();
    nabp_angle_feeder_if #(.kAngleLength(8), .kSLength(9), .kDataLength(16)) if_c ();

    nabp_angle_feeder #(.kNoOfAngles(3), .kAngleStep(1), .kMemLatency(2)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
        .hs(if_a), .mem_addr(mem_addr_a), .mem_rd(mem_rd_a), .mem_data(mem_data_a));
    nabp_angle_feeder #(.kNoOfAngles(4), .kAngleStep(100), .kMemLatency(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
        .hs(if_b), .mem_addr(mem_addr_b), .mem_rd(mem_rd_b), .mem_data(mem_data_b));
    nabp_angle_feeder #(.kNoOfAngles(1), .kAngleStep(1), .kMemLatency(2)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .busy(busy_c), .done(done_c),
        .hs(if_c), .mem_addr(mem_addr_c), .mem_rd(mem_rd_c), .mem_data(mem_data_c));

    assign mem_data_b = '0;
    assign mem_data_c = '0;

    // Sinogram word at (row, col).
    function automatic logic [15:0] mem_word(input logic [7:0] row, input logic [8:0] col);
        return 16'((row * 300 + col) ^ 16'hA5A5);
    endfunction

    // Two-cycle-latency memory model for instance A.
    logic [15:0] mem_pipe0, mem_pipe1;
    always @(posedge clk) begin
        mem_pipe0 <= mem_word(mem_addr_a[16:9], mem_addr_a[8:0]);
        mem_pipe1 <= mem_pipe0;
    end
    assign mem_data_a = mem_pipe1;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [7:0]  angle_q_a[$], angle_q_b[$], angle_q_c[$];
    logic [15:0] data_exp_q[$];
    int          data_due_q[$];
    int          scan_acks_a = 0, scan_acks_b = 0, scan_acks_c = 0;
    int          done_cnt_a = 0, done_cnt_b = 0, done_cnt_c = 0;
    logic        prev_ack_a = 1'b0, prev_ack_b = 1'b0, prev_ack_c = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_busy"},     32'(busy_a), 32'd0);
        check({tag, "_done"},     32'(done_a), 32'd0);
        check({tag, "_angle"},    32'(if_a.hs_angle), 32'd0);
        check({tag, "_has_next"}, 32'(if_a.hs_has_next_angle), 32'd0);
        check({tag, "_ack"},      32'(if_a.hs_next_angle_ack), 32'd0);
        check({tag, "_mem_rd"},   32'(mem_rd_a), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr_a), 32'd0);
        check({tag, "_hs_val"},   32'(if_a.hs_val), 32'd0);
    endtask

    // One clock; then scoreboard pops for data and acks on every instance.
    task automatic step();
        logic [15:0] exp_word;
        int          due;
        @(posedge clk);
        #1;
        cyc++;
        if (data_due_q.size() > 0 && data_due_q[0] == cyc) begin
            due      = data_due_q.pop_front();
            exp_word = data_exp_q.pop_front();
            check($sformatf("hs_val_a@%0d", due), 32'(if_a.hs_val), 32'(exp_word));
        end

        if (prev_ack_a) check("has_next_after_ack_a", 32'(if_a.hs_has_next_angle), 32'(scan_acks_a < 3));
        if (if_a.hs_next_angle_ack) begin
            check("ack_gap_a", 32'(prev_ack_a), 32'd0);
            check("has_next_at_ack_a", 32'(if_a.hs_has_next_angle), 32'd1);
            if (angle_q_a.size() > 0) check("angle_a", 32'(if_a.hs_angle), 32'(angle_q_a.pop_front()));
            else check("ack_a_unexpected", 32'(angle_q_a.size()), 32'd1);
            scan_acks_a++;
        end
        if (done_a) done_cnt_a++;
        prev_ack_a = if_a.hs_next_angle_ack;

        if (prev_ack_b) check("has_next_after_ack_b", 32'(if_b.hs_has_next_angle), 32'(scan_acks_b < 4));
        if (if_b.hs_next_angle_ack) begin
            check("ack_gap_b", 32'(prev_ack_b), 32'd0);
            if (angle_q_b.size() > 0) check("angle_b", 32'(if_b.hs_angle), 32'(angle_q_b.pop_front()));
            else check("ack_b_unexpected", 32'(angle_q_b.size()), 32'd1);
            scan_acks_b++;
        end
        if (done_b) done_cnt_b++;
        prev_ack_b = if_b.hs_next_angle_ack;

        if (prev_ack_c) check("has_next_after_ack_c", 32'(if_c.hs_has_next_angle), 32'(scan_acks_c < 1));
        if (if_c.hs_next_angle_ack) begin
            check("ack_gap_c", 32'(prev_ack_c), 32'd0);
            if (angle_q_c.size() > 0) check("angle_c", 32'(if_c.hs_angle), 32'(angle_q_c.pop_front()));
            else check("ack_c_unexpected", 32'(angle_q_c.size()), 32'd1);
            scan_acks_c++;
        end
        if (done_c) done_cnt_c++;
        prev_ack_c = if_c.hs_next_angle_ack;
    endtask

    initial begin
        logic s_driven;
        int   addr_chk_cyc;

        reset = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        if_a.hs_next_angle = 1'b0; if_b.hs_next_angle = 1'b0; if_c.hs_next_angle = 1'b0;
        if_a.hs_s_val = '0; if_b.hs_s_val = '0; if_c.hs_s_val = '0;
        step();
        step();
        check_reset_a("reset");
        reset = 1'b0;
        step();

        // Scan of 3 angles with the request held high; sample read after 2nd ack.
        angle_q_a.push_back(8'd0); angle_q_a.push_back(8'd1); angle_q_a.push_back(8'd2);
        start_a = 1'b1;
        if_a.hs_next_angle = 1'b1;
        step();
        start_a = 1'b0;
        check("busy_rise_a", 32'(busy_a), 32'd1);
        check("no_ack_with_start_a", 32'(if_a.hs_next_angle_ack), 32'd0);
        check("has_next_start_a", 32'(if_a.hs_has_next_angle), 32'd1);
        check("angle_start_a", 32'(if_a.hs_angle), 32'd0);
        s_driven = 1'b0;
        addr_chk_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (cyc == addr_chk_cyc) begin
                check("mem_addr_row1_col5", 32'(mem_addr_a), 32'({8'd1, 9'd5}));
                check("mem_rd_active", 32'(mem_rd_a), 32'd1);
            end
            if (scan_acks_a == 2 && !if_a.hs_next_angle_ack && !s_driven) begin
                if_a.hs_s_val = 9'd5;
                data_exp_q.push_back(mem_word(8'd1, 9'd5));
                data_due_q.push_back(cyc + 4);
                addr_chk_cyc = cyc + 1;
                s_driven = 1'b1;
            end
            if (done_cnt_a > 0 && data_due_q.size() == 0) break;
        end
        check("acks_scan1_a", 32'(scan_acks_a), 32'd3);
        check("done_scan1_a", 32'(done_cnt_a), 32'd1);
        check("busy_fall_a", 32'(busy_a), 32'd0);
        check("has_next_end_a", 32'(if_a.hs_has_next_angle), 32'd0);
        check("angles_left_a", 32'(angle_q_a.size()), 32'd0);
        check("data_left_a", 32'(data_due_q.size()), 32'd0);
        if_a.hs_next_angle = 1'b0;
        step();

        // Reset during the second offer.
        scan_acks_a = 0; done_cnt_a = 0;
        angle_q_a.push_back(8'd0);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        if_a.hs_next_angle = 1'b1;
        step();
        if_a.hs_next_angle = 1'b0;
        step();
        check("second_offer_angle_a", 32'(if_a.hs_angle), 32'd1);
        #1 reset = 1'b1;
        #1 check_reset_a("midscan_reset");
        step();
        reset = 1'b0;
        step();

        // Restart from angle 0 / fill_idx 0, with a start pulse while busy.
        scan_acks_a = 0; done_cnt_a = 0;
        angle_q_a.push_back(8'd0); angle_q_a.push_back(8'd1); angle_q_a.push_back(8'd2);
        start_a = 1'b1;
        if_a.hs_s_val = 9'd7;
        data_exp_q.push_back(mem_word(8'd0, 9'd7));
        data_due_q.push_back(cyc + 4);
        step();
        start_a = 1'b0;
        check("restart_angle_a", 32'(if_a.hs_angle), 32'd0);
        check("restart_fill_idx_a", 32'(mem_addr_a), 32'({8'd0, 9'd7}));
        if_a.hs_next_angle = 1'b1;
        step();
        if_a.hs_next_angle = 1'b0;
        step();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        check("start_busy_angle_a", 32'(if_a.hs_angle), 32'd1);
        check("start_busy_busy_a", 32'(busy_a), 32'd1);
        step();
        check("start_busy_hold_a", 32'(if_a.hs_angle), 32'd1);
        if_a.hs_next_angle = 1'b1;
        for (int i = 0; i < 30 && done_cnt_a == 0; i++) step();
        if_a.hs_next_angle = 1'b0;
        check("acks_scan3_a", 32'(scan_acks_a), 32'd3);
        check("done_scan3_a", 32'(done_cnt_a), 32'd1);
        check("angles_left3_a", 32'(angle_q_a.size()), 32'd0);
        check("data_left3_a", 32'(data_due_q.size()), 32'd0);

        // Angle wrap: step 100, 4 angles.
        angle_q_b.push_back(8'd0); angle_q_b.push_back(8'd100);
        angle_q_b.push_back(8'd200); angle_q_b.push_back(8'd44);
        start_b = 1'b1;
        if_b.hs_next_angle = 1'b1;
        step();
        start_b = 1'b0;
        for (int i = 0; i < 40 && done_cnt_b == 0; i++) step();
        if_b.hs_next_angle = 1'b0;
        check("acks_b", 32'(scan_acks_b), 32'd4);
        check("done_b", 32'(done_cnt_b), 32'd1);
        check("busy_fall_b", 32'(busy_b), 32'd0);
        check("angles_left_b", 32'(angle_q_b.size()), 32'd0);

        // Single-angle scan.
        angle_q_c.push_back(8'd0);
        start_c = 1'b1;
        if_c.hs_next_angle = 1'b1;
        step();
        start_c = 1'b0;
        for (int i = 0; i < 20 && done_cnt_c == 0; i++) step();
        step();
        step();
        if_c.hs_next_angle = 1'b0;
        check("acks_c", 32'(scan_acks_c), 32'd1);
        check("done_c", 32'(done_cnt_c), 32'd1);
        check("has_next_end_c", 32'(if_c.hs_has_next_angle), 32'd0);
        check("busy_fall_c", 32'(busy_c), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
